// File: rtl/rom_loader.sv
// Loads 32 bytes from a valid/ready stream into a 32x8 store, or clears all 32 locations.
// Optional running checksum of loaded bytes is built when ROM_LOADER_CHECKSUM_EN is defined.
module rom_loader #(
   parameter int unsigned HOLD_CYCLES = 2
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Start,
   input  logic       ClearAll,
   input  logic [7:0] Din,
   input  logic       DinValid,
   output logic       DinReady,
   output logic       Load,
   output logic       Clear,
   output logic [4:0] A,
   output logic [7:0] D,
   output logic       Busy,
   output logic       Done,
   output logic [5:0] Count,
   output logic [7:0] Checksum
);

   localparam logic [3:0] HoldLast = 4'(HOLD_CYCLES - 1);
   localparam logic [4:0] AddrLast = 5'd31;

   typedef enum logic [2:0] {
      StIdle,
      StWaitData,
      StWrite,
      StClr,
      StDone
   } state_e;

   state_e     state_q, state_d;
   logic [4:0] addr_q, addr_d;
   logic [5:0] cnt_q, cnt_d;
   logic [7:0] data_q, data_d;
   logic [3:0] hold_q, hold_d;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= StIdle;
         addr_q  <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         hold_q  <= hold_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      hold_d  = hold_q;
      unique case (state_q)
         StIdle: begin
            // ClearAll takes priority over a simultaneous Start
            if (ClearAll) begin
               addr_d  = '0;
               cnt_d   = '0;
               hold_d  = '0;
               state_d = StClr;
            end else if (Start) begin
               addr_d  = '0;
               cnt_d   = '0;
               state_d = StWaitData;
            end
         end
         StWaitData: begin
            if (DinValid) begin
               data_d  = Din;
               hold_d  = '0;
               state_d = StWrite;
            end
         end
         StWrite: begin
            if (hold_q == HoldLast) begin
               hold_d = '0;
               cnt_d  = cnt_q + 6'd1;
               if (addr_q == AddrLast) begin
                  state_d = StDone;
               end else begin
                  addr_d  = addr_q + 5'd1;
                  state_d = StWaitData;
               end
            end else begin
               hold_d = hold_q + 4'd1;
            end
         end
         StClr: begin
            if (hold_q == HoldLast) begin
               hold_d = '0;
               cnt_d  = cnt_q + 6'd1;
               if (addr_q == AddrLast) begin
                  state_d = StDone;
               end else begin
                  addr_d = addr_q + 5'd1;
               end
            end else begin
               hold_d = hold_q + 4'd1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs decode straight from state so reset clears them without waiting for a clock
   assign DinReady = (state_q == StWaitData);
   assign Load     = (state_q == StWrite);
   assign Clear    = (state_q == StClr);
   assign Busy     = (state_q != StIdle);
   assign Done     = (state_q == StDone);
   assign A        = addr_q;
   assign D        = data_q;
   assign Count    = cnt_q;

`ifdef ROM_LOADER_CHECKSUM_EN
   logic [7:0] csum_q, csum_d;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         csum_q <= '0;
      end else begin
         csum_q <= csum_d;
      end
   end

   always_comb begin
      csum_d = csum_q;
      if ((state_q == StIdle) && Start && !ClearAll) begin
         csum_d = '0;
      end else if ((state_q == StWaitData) && DinValid) begin
         csum_d = csum_q + Din;
      end
   end

   assign Checksum = csum_q;
`else
   assign Checksum = '0;
`endif

endmodule

// File: tb/tb_rom_loader.sv
// Directed self-checking bench for rom_loader: load, clear, priority, stall, abort and checksum.
module tb_rom_loader;

   localparam int unsigned HoldCycles = 2;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       Start;
   logic       ClearAll;
   logic [7:0] Din;
   logic       DinValid;
   logic       DinReady;
   logic       Load;
   logic       Clear;
   logic [4:0] A;
   logic [7:0] D;
   logic       Busy;
   logic       Done;
   logic [5:0] Count;
   logic [7:0] Checksum;

   int checks = 0;
   int errors = 0;
   logic [7:0] vec [32];
   logic [7:0] exp_csum = 8'h00;

   rom_loader #(
      .HOLD_CYCLES(HoldCycles)
   ) dut (
      .Clk     (Clk),
      .Reset   (Reset),
      .Start   (Start),
      .ClearAll(ClearAll),
      .Din     (Din),
      .DinValid(DinValid),
      .DinReady(DinReady),
      .Load    (Load),
      .Clear   (Clear),
      .A       (A),
      .D       (D),
      .Busy    (Busy),
      .Done    (Done),
      .Count   (Count),
      .Checksum(Checksum)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // Full 32-byte session from vec[], checking every cycle
   task automatic load_session();
      logic [7:0] sum;
      sum = 8'h00;
      Start = 1'b1;
      step();
      Start = 1'b0;
      DinValid = 1'b1;
      for (int i = 0; i < 32; i++) begin
         check("ld_ready", 32'(DinReady), 32'd1);
         check("ld_wait_load", 32'(Load), 32'd0);
         check("ld_wait_addr", 32'(A), 32'(i));
         check("ld_wait_count", 32'(Count), 32'(i));
         Din = vec[i];
         sum = sum + vec[i];
         step();
         for (int h = 0; h < int'(HoldCycles); h++) begin
            check("ld_load", 32'(Load), 32'd1);
            check("ld_clear", 32'(Clear), 32'd0);
            check("ld_addr", 32'(A), 32'(i));
            check("ld_data", 32'(D), 32'(vec[i]));
            check("ld_noready", 32'(DinReady), 32'd0);
            step();
         end
      end
      DinValid = 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
      exp_csum = sum;
`else
      exp_csum = 8'h00;
`endif
      check("ld_done", 32'(Done), 32'd1);
      check("ld_done_load", 32'(Load), 32'd0);
      check("ld_done_count", 32'(Count), 32'd32);
      step();
      check("ld_end_done", 32'(Done), 32'd0);
      check("ld_end_busy", 32'(Busy), 32'd0);
      check("ld_end_addr", 32'(A), 32'd31);
      check("ld_end_count", 32'(Count), 32'd32);
      check("ld_checksum", 32'(Checksum), 32'(exp_csum));
   endtask

   task automatic clear_session(input logic with_start);
      Start = with_start;
      ClearAll = 1'b1;
      step();
      Start = 1'b0;
      ClearAll = 1'b0;
      for (int k = 0; k < 32 * int'(HoldCycles); k++) begin
         check("clr_clear", 32'(Clear), 32'd1);
         check("clr_load", 32'(Load), 32'd0);
         check("clr_ready", 32'(DinReady), 32'd0);
         check("clr_addr", 32'(A), 32'(k / int'(HoldCycles)));
         check("clr_count", 32'(Count), 32'(k / int'(HoldCycles)));
         step();
      end
      check("clr_done", 32'(Done), 32'd1);
      check("clr_done_clear", 32'(Clear), 32'd0);
      check("clr_done_count", 32'(Count), 32'd32);
      step();
      check("clr_end_busy", 32'(Busy), 32'd0);
      check("clr_end_done", 32'(Done), 32'd0);
      check("clr_checksum", 32'(Checksum), 32'(exp_csum));
   endtask

   initial begin
      Reset = 1'b1;
      Start = 1'b0;
      ClearAll = 1'b0;
      Din = 8'h00;
      DinValid = 1'b0;
      #2;
      check("rst_load", 32'(Load), 32'd0);
      check("rst_clear", 32'(Clear), 32'd0);
      check("rst_addr", 32'(A), 32'd0);
      check("rst_data", 32'(D), 32'd0);
      check("rst_ready", 32'(DinReady), 32'd0);
      check("rst_busy", 32'(Busy), 32'd0);
      check("rst_done", 32'(Done), 32'd0);
      check("rst_count", 32'(Count), 32'd0);
      check("rst_checksum", 32'(Checksum), 32'd0);
      step();
      Reset = 1'b0;
      step();
      check("idle_busy", 32'(Busy), 32'd0);

      // Bytes 0x00..0x1F
      for (int i = 0; i < 32; i++) vec[i] = 8'(i);
      load_session();

      clear_session(1'b0);
      // Start with ClearAll: clear wins, checksum untouched
      clear_session(1'b1);

      // Stall after three bytes
      Start = 1'b1;
      step();
      Start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         Din = 8'(8'hA0 + i);
         DinValid = 1'b1;
         step();
         DinValid = 1'b0;
         repeat (HoldCycles) step();
      end
      for (int c = 0; c < 10; c++) begin
         Start = (c == 4);
         ClearAll = (c == 6);
         check("stall_busy", 32'(Busy), 32'd1);
         check("stall_ready", 32'(DinReady), 32'd1);
         check("stall_addr", 32'(A), 32'd3);
         check("stall_count", 32'(Count), 32'd3);
         check("stall_load", 32'(Load), 32'd0);
         check("stall_clear", 32'(Clear), 32'd0);
         step();
      end
      Start = 1'b0;
      ClearAll = 1'b0;
      check("stall_post_addr", 32'(A), 32'd3);

      // Two more bytes, then abort in the middle of the write at A=5
      for (int i = 3; i < 6; i++) begin
         Din = 8'(8'hA0 + i);
         DinValid = 1'b1;
         step();
         DinValid = 1'b0;
         if (i < 5) repeat (HoldCycles) step();
      end
      check("abort_pre_load", 32'(Load), 32'd1);
      check("abort_pre_addr", 32'(A), 32'd5);
      Reset = 1'b1;
      #1;
      check("abort_load", 32'(Load), 32'd0);
      check("abort_addr", 32'(A), 32'd0);
      check("abort_busy", 32'(Busy), 32'd0);
      check("abort_count", 32'(Count), 32'd0);
      step();
      Reset = 1'b0;
      step();
      check("abort_idle_load", 32'(Load), 32'd0);
      check("abort_idle_busy", 32'(Busy), 32'd0);

      // 0x66 + 0xC3 = 0x129 -> 0x29
      vec[0] = 8'h66;
      vec[1] = 8'hC3;
      for (int i = 2; i < 32; i++) vec[i] = 8'h00;
      load_session();
`ifdef ROM_LOADER_CHECKSUM_EN
      check("csum_value", 32'(Checksum), 32'h29);
`else
      check("csum_value", 32'(Checksum), 32'h00);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 2: cycles (1..15) for which each write or clear strobe is held on the store interface.
REQ-002 The block SHALL have port Clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port Start, input, 1, a single-cycle pulse that begins a 32-byte load session.
REQ-005 The block SHALL have port ClearAll, input, 1, a single-cycle pulse that begins a clear of all 32 locations.
REQ-006 The block SHALL have port Din, input, 8, the incoming byte.
REQ-007 The block SHALL have port DinValid, input, 1, meaning Din holds a byte.
REQ-008 The block SHALL have port DinReady, output, 1, meaning the loader accepts Din this cycle.
REQ-009 The block SHALL have port Load, output, 1, the write strobe to the 32x8 store.
REQ-010 The block SHALL have port Clear, output, 1, the clear strobe to the store.
REQ-011 The block SHALL have port A, output, 5, the store address.
REQ-012 The block SHALL have port D, output, 8, the store write data.
REQ-013 The block SHALL have port Busy, output, 1, high in every state except IDLE.
REQ-014 The block SHALL have port Done, output, 1, a one-cycle pulse when a session completes.
REQ-015 The block SHALL have port Count, output, 6, the locations written or cleared in the current session (0..32).
REQ-016 The block SHALL have port Checksum, output, 8, the sum modulo 256 of the bytes written (see REQ-032).

Function
REQ-017 The FSM SHALL have exactly the states IDLE, WAIT_DATA, WRITE, CLR, DONE.
REQ-018 In IDLE, a Start pulse SHALL set the address to 0 and Count to 0, and move to WAIT_DATA on the next edge.
REQ-019 In IDLE, a ClearAll pulse SHALL set the address to 0 and Count to 0, and move to CLR; ClearAll SHALL win when it arrives with Start in the same cycle.
REQ-020 Start and ClearAll SHALL be ignored in every state except IDLE.
REQ-021 DinReady SHALL be 1 only in WAIT_DATA; a handshake occurs on an edge where DinValid=1 and DinReady=1.
REQ-022 On a handshake, the block SHALL register Din into D and move to WRITE; DinValid without DinReady SHALL be ignored.
REQ-023 In WRITE, Load SHALL be 1, A SHALL hold the current address and D SHALL hold the captured byte for exactly HOLD_CYCLES cycles.
REQ-024 At the end of WRITE, Count SHALL increment; if the address was 31 the FSM SHALL go to DONE, otherwise the address SHALL increment and the FSM SHALL return to WAIT_DATA.
REQ-025 In CLR, Clear SHALL be 1 for HOLD_CYCLES cycles at each address 0..31 in turn, with Count incrementing per address, followed by DONE.
REQ-026 DONE SHALL last one cycle with Done=1, then return to IDLE; Count and A SHALL hold their last values until the next Start or ClearAll.
REQ-027 Load and Clear SHALL never both be 1; both SHALL be 0 outside WRITE and CLR.
REQ-028 The address counter SHALL be 5 bits wide and SHALL not be wrapped within a session; the maximum session write is address 31.
REQ-029 Latency: Load SHALL rise on the edge after the handshake, and the minimum per-byte period SHALL be HOLD_CYCLES+1 cycles.

Reset
REQ-030 Reset=1 SHALL immediately force IDLE, Load=0, Clear=0, A=0, D=0, DinReady=0, Busy=0, Done=0, Count=0, Checksum=0, independent of Clk.
REQ-031 A reset during WRITE or CLR SHALL abort the session with no further strobes; the locations already written SHALL not be revisited.

Configuration
REQ-032 With macro ROM_LOADER_CHECKSUM_EN defined, Checksum SHALL clear on Start and add each byte at its handshake (mod 256), and SHALL be unchanged by ClearAll; without the macro, Checksum SHALL be tied to 0 and no adder SHALL be built.

Verification
REQ-033 Reset, then Start, then bytes 0x00..0x1F each with DinValid held -> 32 Load pulses each 2 cycles wide at A=0..31 with D=A, Done pulses once, Count=32.
REQ-034 ClearAll -> Clear high for 64 consecutive cycles with A stepping every 2 cycles from 0 to 31, Load=0 throughout, Done pulses, Count=32.
REQ-035 Start and ClearAll in the same cycle -> a clear session runs and DinReady stays 0.
REQ-036 Start, 3 bytes, then DinValid=0 for 10 cycles -> the block stays in WAIT_DATA with Busy=1, A=3, Count=3, and no strobes.
REQ-037 Reset asserted mid-WRITE at A=5 -> Load=0 and A=0 before the next Clk edge, and Busy=0.
REQ-038 With ROM_LOADER_CHECKSUM_EN defined, load bytes 0x66, 0xC3, then 30 bytes of 0x00 -> Checksum=0x29; without the macro, Checksum=0x00.
